// File: rtl/mem_port_sequencer.sv
// mem_port_sequencer: frame sequencer for one shared image RAM port.
// Walks LOAD -> PROC -> UNLOAD -> DONE and registers the RAM port from whichever side owns it.
// The processor is gated by a registered clock enable, never by a muxed clock.
module mem_port_sequencer #(
  parameter int unsigned ADDR_W       = 18,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned LOAD_BYTES   = 65536,
  parameter int unsigned PROC_TIMEOUT = 16777215
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_wr,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [DATA_W-1:0] uart_din,
  input  logic              pro_wr,
  input  logic [ADDR_W-1:0] pro_addr,
  input  logic [DATA_W-1:0] pro_din,
  input  logic              pro_finish,
  input  logic [ADDR_W-1:0] tx_addr,
  input  logic              tx_end,
  output logic              pro_start,
  output logic              pro_ce,
  output logic              tx_start,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   load_cnt,
  output logic              timeout_err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned WD_W  = (PROC_TIMEOUT > 1) ? $clog2(PROC_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'b00,
    ST_PROC   = 2'b01,
    ST_UNLOAD = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    load_cnt_q, load_cnt_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic                timeout_err_q, timeout_err_d;
  logic                pro_start_q, pro_start_d;
  logic                pro_ce_q, pro_ce_d;
  logic                tx_start_q, tx_start_d;
  logic                mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_din_q, mem_din_d;

  logic last_byte;
  logic wdog_expired;

  assign last_byte    = (load_cnt_q == CNT_W'(LOAD_BYTES - 1));
  assign wdog_expired = (PROC_TIMEOUT != 0) && (wdog_q == WD_W'(PROC_TIMEOUT - 1));

  // Next-state, port mux and strobe generation
  always_comb begin
    state_d       = state_q;
    load_cnt_d    = load_cnt_q;
    wdog_d        = wdog_q;
    timeout_err_d = timeout_err_q;
    mem_wr_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_din_d     = mem_din_q;

    case (state_q)
      ST_LOAD: begin
        mem_wr_d   = uart_wr;
        mem_addr_d = uart_addr;
        mem_din_d  = uart_din;
        if (uart_wr) begin
          load_cnt_d = load_cnt_q + CNT_W'(1);
          if (last_byte) begin
            state_d = ST_PROC;
            wdog_d  = '0;
          end
        end
      end
      ST_PROC: begin
        mem_wr_d   = pro_wr;
        mem_addr_d = pro_addr;
        mem_din_d  = pro_din;
        if (pro_finish) begin
          state_d = ST_UNLOAD;
        end else if (wdog_expired) begin
          state_d       = ST_UNLOAD;
          timeout_err_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      ST_UNLOAD: begin
        mem_addr_d = tx_addr;
        mem_din_d  = '0;
        // tx_end coinciding with the tx_start pulse belongs to a stale frame
        if (tx_end && !tx_start_q) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        // First byte of the next frame restarts the sequence and is kept
        if (uart_wr) begin
          mem_wr_d      = 1'b1;
          mem_addr_d    = uart_addr;
          mem_din_d     = uart_din;
          load_cnt_d    = CNT_W'(1);
          timeout_err_d = 1'b0;
          wdog_d        = '0;
          state_d       = (LOAD_BYTES == 1) ? ST_PROC : ST_LOAD;
        end
      end
    endcase

    pro_start_d = (state_d == ST_PROC) && (state_q != ST_PROC);
    pro_ce_d    = (state_d == ST_PROC);
    tx_start_d  = (state_d == ST_UNLOAD) && (state_q != ST_UNLOAD);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_LOAD;
      load_cnt_q    <= '0;
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
      pro_start_q   <= 1'b0;
      pro_ce_q      <= 1'b0;
      tx_start_q    <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
    end else begin
      state_q       <= state_d;
      load_cnt_q    <= load_cnt_d;
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
      pro_start_q   <= pro_start_d;
      pro_ce_q      <= pro_ce_d;
      tx_start_q    <= tx_start_d;
      mem_wr_q      <= mem_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
    end
  end

  assign state       = state_q;
  assign load_cnt    = load_cnt_q;
  assign timeout_err = timeout_err_q;
  assign pro_start   = pro_start_q;
  assign pro_ce      = pro_ce_q;
  assign tx_start    = tx_start_q;
  assign mem_wr      = mem_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer with a 4-byte frame and a 16-cycle watchdog.
module tb_mem_port_sequencer;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              uart_wr;
  logic [ADDR_W-1:0] uart_addr;
  logic [DATA_W-1:0] uart_din;
  logic              pro_wr;
  logic [ADDR_W-1:0] pro_addr;
  logic [DATA_W-1:0] pro_din;
  logic              pro_finish;
  logic [ADDR_W-1:0] tx_addr;
  logic              tx_end;
  logic              pro_start;
  logic              pro_ce;
  logic              tx_start;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [1:0]        state;
  logic [ADDR_W:0]   load_cnt;
  logic              timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  mem_port_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOAD_BYTES(4), .PROC_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .uart_wr(uart_wr), .uart_addr(uart_addr), .uart_din(uart_din),
    .pro_wr(pro_wr), .pro_addr(pro_addr), .pro_din(pro_din), .pro_finish(pro_finish),
    .tx_addr(tx_addr), .tx_end(tx_end),
    .pro_start(pro_start), .pro_ce(pro_ce), .tx_start(tx_start),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
    .state(state), .load_cnt(load_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Compare one observed value with its expected value
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    uart_wr = 1'b0; uart_addr = '0; uart_din = '0;
    pro_wr = 1'b0; pro_addr = '0; pro_din = '0; pro_finish = 1'b0;
    tx_addr = '0; tx_end = 1'b0;
  endtask

  task automatic uart(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    uart_wr = 1'b1; uart_addr = a; uart_din = d;
    step();
    uart_wr = 1'b0;
  endtask

  // Load bytes 2..4 of a restarted frame and confirm entry to PROC
  task automatic finish_reload(input string tag);
    for (int i = 1; i < 4; i++) uart(ADDR_W'(i), DATA_W'(8'hB0 + i));
    check({tag, "_state"}, 64'(state), 64'd1);
    check({tag, "_cnt"}, 64'(load_cnt), 64'd4);
    check({tag, "_pstart"}, 64'(pro_start), 64'd1);
  endtask

  logic [63:0] all_out;

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    all_out = {pro_start, pro_ce, tx_start, mem_wr, mem_addr, mem_din, state, load_cnt, timeout_err};
    check("reset_outputs", all_out, 64'd0);
    rst = 1'b0;

    // Processor strobe during LOAD is dropped
    pro_wr = 1'b1; pro_addr = 18'h00055; pro_din = 8'h11;
    step();
    pro_wr = 1'b0;
    check("load_drop_pro_wr", 64'(mem_wr), 64'd0);
    check("load_drop_cnt", 64'(load_cnt), 64'd0);

    // Frame load: four bytes, each forwarded one cycle later
    for (int i = 0; i < 4; i++) begin
      uart(ADDR_W'(i), DATA_W'(8'hA0 + i));
      check("load_wr", 64'(mem_wr), 64'd1);
      check("load_addr", 64'(mem_addr), 64'(i));
      check("load_din", 64'(mem_din), 64'(8'hA0 + i));
      check("load_cnt", 64'(load_cnt), 64'(i + 1));
      check("load_state", 64'(state), (i == 3) ? 64'd1 : 64'd0);
    end
    check("pro_start_pulse", 64'(pro_start), 64'd1);
    check("pro_ce_on", 64'(pro_ce), 64'd1);

    // PROC cycle 1 -> 2: pulse drops
    step();
    check("pro_start_one", 64'(pro_start), 64'd0);
    check("proc_state", 64'(state), 64'd1);

    // UART strobe during PROC is dropped, count holds
    uart(18'h00005, 8'h77);
    check("proc_drop_uart", 64'(mem_wr), 64'd0);
    check("proc_cnt_hold", 64'(load_cnt), 64'd4);

    // Processor write at the top address
    pro_wr = 1'b1; pro_addr = 18'h3FFFF; pro_din = 8'h5A;
    step();
    pro_wr = 1'b0;
    check("pro_wr", 64'(mem_wr), 64'd1);
    check("pro_addr", 64'(mem_addr), 64'h3FFFF);
    check("pro_din", 64'(mem_din), 64'h5A);

    // PROC cycle 5: finish
    step();
    pro_finish = 1'b1;
    step();
    check("unload_state", 64'(state), 64'd2);
    check("tx_start_pulse", 64'(tx_start), 64'd1);
    check("pro_ce_off", 64'(pro_ce), 64'd0);
    check("no_timeout", 64'(timeout_err), 64'd0);

    // tx_end alongside tx_start is ignored; pro_finish stays high
    tx_end = 1'b1; tx_addr = 18'h00123;
    step();
    check("tx_end_ignored", 64'(state), 64'd2);
    check("tx_start_one", 64'(tx_start), 64'd0);
    check("tx_addr0", 64'(mem_addr), 64'h123);
    check("tx_din0", 64'(mem_din), 64'd0);
    check("tx_wr0", 64'(mem_wr), 64'd0);
    tx_end = 1'b0; tx_addr = 18'h00124;
    step();
    check("tx_addr1", 64'(mem_addr), 64'h124);
    tx_end = 1'b1; tx_addr = 18'h00125;
    step();
    check("done_state", 64'(state), 64'd3);
    check("done_addr_last", 64'(mem_addr), 64'h125);
    tx_end = 1'b0; tx_addr = 18'h00200;
    step();
    check("done_hold_state", 64'(state), 64'd3);
    check("done_hold_addr", 64'(mem_addr), 64'h125);
    check("done_wr", 64'(mem_wr), 64'd0);
    pro_finish = 1'b0;

    // Restart from DONE
    uart(18'h00010, 8'hC0);
    check("restart_state", 64'(state), 64'd0);
    check("restart_cnt", 64'(load_cnt), 64'd1);
    check("restart_wr", 64'(mem_wr), 64'd1);
    check("restart_addr", 64'(mem_addr), 64'h10);
    check("restart_din", 64'(mem_din), 64'hC0);
    finish_reload("reload1");

    // Watchdog expiry after 16 PROC cycles
    repeat (15) step();
    check("wd_still_proc", 64'(state), 64'd1);
    check("wd_no_err_yet", 64'(timeout_err), 64'd0);
    step();
    check("wd_state", 64'(state), 64'd2);
    check("wd_err", 64'(timeout_err), 64'd1);
    check("wd_tx_start", 64'(tx_start), 64'd1);
    step();
    tx_end = 1'b1;
    step();
    tx_end = 1'b0;
    check("wd_done", 64'(state), 64'd3);
    check("wd_sticky", 64'(timeout_err), 64'd1);

    // Restart clears the sticky error
    uart(18'h00000, 8'hC1);
    check("restart_clr_err", 64'(timeout_err), 64'd0);
    finish_reload("reload2");

    // Finish on the expiry cycle wins
    repeat (15) step();
    pro_finish = 1'b1;
    step();
    pro_finish = 1'b0;
    check("tie_state", 64'(state), 64'd2);
    check("tie_no_err", 64'(timeout_err), 64'd0);

    // Back to PROC, then asynchronous reset between edges
    step();
    tx_end = 1'b1;
    step();
    tx_end = 1'b0;
    uart(18'h00000, 8'hC2);
    finish_reload("reload3");
    pro_wr = 1'b1; pro_addr = 18'h00042; pro_din = 8'h99;
    step();
    pro_wr = 1'b0;
    check("pre_rst_wr", 64'(mem_wr), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    all_out = {pro_start, pro_ce, tx_start, mem_wr, mem_addr, mem_din, state, load_cnt, timeout_err};
    check("async_rst_outputs", all_out, 64'd0);
    check("async_rst_pro_ce", 64'(pro_ce), 64'd0);
    step();
    rst = 1'b0;
    uart(18'h00007, 8'hEE);
    check("post_rst_cnt", 64'(load_cnt), 64'd1);
    check("post_rst_addr", 64'(mem_addr), 64'h7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
